issue_rr_arbiter_9: RTL
=======================

# issue_rr_arbiter_9

Round-robin arbiter for the issue stage, selecting one of 9 requesting slots per grant with rotating priority. It keeps a priority pointer register and drives it as the 4-bit rotate amount into the 9-bit circular barrel shifter. It then takes the lowest set bit of the rotated vector and maps it back to an absolute slot index. The registered grant is held until the downstream issue logic acknowledges or flushes it.

## Interface
- NUM_REQ, 9: request slots; only 9 is supported (matches the 9-bit rotate).
- IDX_W, 4: width of slot index and pointer.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low. Sampled at the rising edge of clk.
- req_valid  in  9  per-slot request; bit k = slot k ready.
- grant_ack  in  1  consumer accepts the current grant; meaningful only while grant_valid=1.
- arb_flush  in  1  drop the current grant without advancing priority.
- grant_valid  out  1  registered; a grant is presented.
- grant_onehot  out  9  registered; one-hot winner, all-zero when grant_valid=0.
- grant_idx  out  4  registered; winner index 0..8, 0 when grant_valid=0.
- prio_ptr  out  4  current priority pointer 0..8, i.e. the slot with highest priority.

## Operation
- State machine with two states.
  - IDLE: no grant is held.
  - HOLD: a grant is presented.
- Arbitration is combinational and is evaluated only in IDLE.
  - rot = req_valid rotated right by prio_ptr, so rot[i] = req_valid[(i+prio_ptr) mod 9].
  - j = lowest set bit of rot.
  - winner = (j + prio_ptr) mod 9, computed as a 4-bit add with one conditional subtract of 9.
- IDLE behaviour:
  - If req_valid != 0 and arb_flush = 0: register the winner into grant_onehot and grant_idx, set grant_valid=1, go to HOLD.
  - If req_valid = 0 or arb_flush = 1: stay in IDLE; outputs stay zero.
- HOLD behaviour:
  - Outputs stay stable; req_valid is ignored. The grant is sticky even if the winner drops its request.
  - On grant_ack=1 with arb_flush=0: prio_ptr <= winner+1, wrapping 8 to 0. Clear outputs and go to IDLE.
  - On arb_flush=1: clear outputs, go to IDLE, prio_ptr unchanged. Flush wins over a simultaneous ack.
  - With neither input asserted: remain in HOLD.
- prio_ptr changes only on an accepted ack and is never greater than 8. The shifter therefore never sees rotate amounts 9..15.

## Timing
- Reset (rst=0 at an edge): state=IDLE, grant_valid=0, grant_onehot=0, grant_idx=0, prio_ptr=0.
  - Reset during HOLD drops the grant with no pointer update.
  - Reset overrides all other inputs in the same cycle.
- Latency: req_valid sampled at edge N in IDLE gives grant_valid=1 after edge N.
- Ack: grant_ack=1 at edge M gives grant_valid=0 and the new prio_ptr after edge M.
  - The next arbitration at edge M+1 uses the new pointer.
  - Maximum throughput is one grant per 2 cycles.
- A grant held for K cycles without ack or flush keeps grant_onehot and grant_idx bit-identical for all K cycles.
- grant_ack or arb_flush asserted in IDLE: no effect, apart from arb_flush suppressing arbitration that cycle.
- Invariants:
  - grant_onehot has exactly one bit set if and only if grant_valid=1.
  - grant_onehot[grant_idx] = 1 whenever grant_valid=1.

## Test plan
- Reset then basic grant: prio_ptr=0, req_valid=9'b000010100 → one cycle later grant_valid=1, grant_idx=2, grant_onehot=9'b000000100. Ack → prio_ptr=3.
- Rotation: prio_ptr=3, req_valid=9'b000010100 → grant_idx=4. Ack → prio_ptr=5. Next grant with req_valid=9'b000010100 → grant_idx=2, because the search wraps past 8.
- Pointer wrap: req_valid=9'b100000000 → grant_idx=8. Ack → prio_ptr=0. Repeat with req_valid=all ones for 9 grants → indices 0,1,...,8 in order.
- Sticky hold: grant_idx=6 held, req_valid drops to 0 for 5 cycles with no ack → outputs unchanged. Ack → prio_ptr=7.
- Flush vs ack: in HOLD with grant_idx=4 and prio_ptr=2, assert arb_flush and grant_ack together → grant_valid=0, prio_ptr stays 2. Next arbitration on req_valid=9'b000010000 → grant_idx=4 again.
- Reset mid-grant: in HOLD with grant_idx=5 and prio_ptr=3, rst=0 for one edge → all outputs 0, prio_ptr=0. With req_valid=all ones after release → grant_idx=0.

Source files
------------

// File: rtl/issue_rr_arbiter_9.sv
// ---------------------------------------------------------------------------
// issue_rr_arbiter_9
//
// Round-robin arbiter for the issue stage. Picks one of 9 requesting slots
// per grant, starting the search at the slot named by the priority pointer.
// The grant is registered and held until the issue logic acknowledges it
// (pointer advances past the winner) or flushes it (pointer unchanged).
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous reset, active low
//   req_valid     per-slot request, bit k = slot k ready
//   grant_ack     consumer accepts the held grant
//   arb_flush     drop the held grant / suppress arbitration this cycle
//   grant_valid   a grant is presented (registered)
//   grant_onehot  one-hot winner, zero when no grant (registered)
//   grant_idx     winner index 0..8, zero when no grant (registered)
//   prio_ptr      slot with highest priority, 0..8
// ---------------------------------------------------------------------------
module issue_rr_arbiter_9 #(
   parameter int NUM_REQ = 9,
   parameter int IDX_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic               grant_ack,
   input  logic               arb_flush,
   output logic               grant_valid,
   output logic [NUM_REQ-1:0] grant_onehot,
   output logic [IDX_W-1:0]   grant_idx,
   output logic [IDX_W-1:0]   prio_ptr
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   logic [0:0]           state_reg,        state_next;
   logic                 grant_valid_reg,  grant_valid_next;
   logic [NUM_REQ-1:0]   grant_onehot_reg, grant_onehot_next;
   logic [IDX_W-1:0]     grant_idx_reg,    grant_idx_next;
   logic [IDX_W-1:0]     prio_ptr_reg,     prio_ptr_next;

   // Requests concatenated with themselves (minus the top bit, which no
   // rotate amount 0..8 can reach) so a plain index implements the wrap.
   logic [2*NUM_REQ-2:0] req_dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [NUM_REQ-1:0]   winner_onehot;
   logic [IDX_W-1:0]     lsb_idx;
   logic [IDX_W:0]       winner_sum;
   logic [IDX_W-1:0]     winner;
   logic [IDX_W-1:0]     ptr_after_ack;

   assign req_dbl = {req_valid[NUM_REQ-2:0], req_valid};

   // Circular barrel shifter: rot[i] = req_valid[(i + prio_ptr) mod 9].
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         assign rot[gi] = req_dbl[{1'b0, prio_ptr_reg} + (IDX_W+1)'(gi)];
      end
   endgenerate

   // Lowest set bit of the rotated vector; scanning downward lets the
   // smallest index be the last (winning) assignment.
   always_comb begin
      lsb_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            lsb_idx = IDX_W'(i);
         end
      end
   end

   // Map back to an absolute slot. The add is one bit wider than the index
   // because lsb_idx + prio_ptr can reach 16 (j=8 with pointer 8).
   assign winner_sum = {1'b0, lsb_idx} + {1'b0, prio_ptr_reg};
   assign winner     = (winner_sum >= (IDX_W+1)'(NUM_REQ))
                       ? IDX_W'(winner_sum - (IDX_W+1)'(NUM_REQ))
                       : winner_sum[IDX_W-1:0];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
         assign winner_onehot[gi] = (winner == IDX_W'(gi));
      end
   endgenerate

   // Pointer moves to the slot just after the accepted winner, wrapping 8->0.
   assign ptr_after_ack = (grant_idx_reg == IDX_W'(NUM_REQ - 1))
                          ? '0 : grant_idx_reg + IDX_W'(1);

   always_comb begin
      state_next        = state_reg;
      grant_valid_next  = grant_valid_reg;
      grant_onehot_next = grant_onehot_reg;
      grant_idx_next    = grant_idx_reg;
      prio_ptr_next     = prio_ptr_reg;
      case (state_reg)
         IDLE: begin
            if ((req_valid != '0) && !arb_flush) begin
               state_next        = HOLD;
               grant_valid_next  = 1'b1;
               grant_onehot_next = winner_onehot;
               grant_idx_next    = winner;
            end
         end
         HOLD: begin
            // Flush takes precedence over a simultaneous ack.
            if (arb_flush || grant_ack) begin
               state_next        = IDLE;
               grant_valid_next  = 1'b0;
               grant_onehot_next = '0;
               grant_idx_next    = '0;
               if (!arb_flush) begin
                  prio_ptr_next = ptr_after_ack;
               end
            end
         end
         default: begin
            state_next        = IDLE;
            grant_valid_next  = 1'b0;
            grant_onehot_next = '0;
            grant_idx_next    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg        <= IDLE;
         grant_valid_reg  <= 1'b0;
         grant_onehot_reg <= '0;
         grant_idx_reg    <= '0;
         prio_ptr_reg     <= '0;
      end else begin
         state_reg        <= state_next;
         grant_valid_reg  <= grant_valid_next;
         grant_onehot_reg <= grant_onehot_next;
         grant_idx_reg    <= grant_idx_next;
         prio_ptr_reg     <= prio_ptr_next;
      end
   end

   assign grant_valid  = grant_valid_reg;
   assign grant_onehot = grant_onehot_reg;
   assign grant_idx    = grant_idx_reg;
   assign prio_ptr     = prio_ptr_reg;

endmodule
